// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial add/subtract sequencer driving an external 1-bit full adder.
//   Operands are captured on an accepted start, fed to the adder LSB first,
//   one bit per cycle, with the carry held in a register between bits. After
//   WIDTH bits the assembled result and final carry are registered and a
//   one-cycle done pulse is raised.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : operation request, sampled only while idle
//   sub               : 0 = a+b+cin, 1 = a+~b+1 (cin ignored)
//   a, b, cin         : operands, captured together with start
//   fa_a, fa_b, fa_cin: bit and carry presented to the full adder (0 when not running)
//   fa_sum, fa_cout   : combinational return from the full adder
//   busy              : high while bits are being processed
//   done              : single-cycle completion pulse
//   sum, cout         : registered result, held until the next completed operation
module serial_add_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry;
   logic [IDX_W-1:0] idx;

   // Shift right and insert a new bit at the MSB. Written without a
   // [WIDTH-1:1] slice so that WIDTH=1 elaborates cleanly.
   function automatic logic [WIDTH-1:0] shift_in_msb(input logic [WIDTH-1:0] sh,
                                                     input logic             bit_in);
      logic [WIDTH-1:0] r;
      r = sh >> 1;
      r[WIDTH-1] = bit_in;
      return r;
   endfunction

   // Sum shift register value after absorbing the bit currently returned
   // by the adder; the last RUN cycle copies this straight into sum.
   assign sum_nxt = shift_in_msb(sum_sh, fa_sum);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (idx == IDX_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: the adder sees register bits only while running, zeros otherwise
   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
      case (state)
         RUN: begin
            busy   = 1'b1;
            fa_a   = a_sh[0];
            fa_b   = b_sh[0];
            fa_cin = carry;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, bit-serial shifting and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
                  a_sh   <= a;
                  b_sh   <= sub ? ~b : b;
                  carry  <= sub ? 1'b1 : cin;
                  idx    <= '0;
                  sum_sh <= '0;
               end
            end
            RUN: begin
               sum_sh <= sum_nxt;
               carry  <= fa_cout;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               idx    <= idx + 1'b1;
               if (idx == IDX_LAST) begin
                  sum  <= sum_nxt;
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
